l1_ahb_mem_responder: RTL and testbench

L1_AHB_MEM_RESPONDER -- requirements
Module: l1_ahb_mem_responder

---
 rtl/l1_ahb_mem_responder_if.sv | 25 ++
 rtl/l1_ahb_mem_responder.sv | 150 +++++++++++++++
 tb/tb_l1_ahb_mem_responder.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_ahb_mem_responder_if.sv
// AHB-Lite slave-side bundle for the L1 memory responder.
// The master modport drives the address/data phase, the slave answers.
interface l1_ahb_mem_responder_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;
    logic [31:0] HRUSER;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA, HRUSER
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA, HRUSER
    );
endinterface

// File: rtl/l1_ahb_mem_responder.sv
// AHB-Lite slave over a word-organised SRAM with configurable wait
// states, two-cycle ERROR responses and per-byte parity on HRUSER.
module l1_ahb_mem_responder #(
    parameter int MEM_AW      = 12,
    parameter int WAIT_STATES = 0
) (
    input logic                   HCLK,
    input logic                   HRESET,
    l1_ahb_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam logic [1:0] WS = 2'(WAIT_STATES);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_cnt;
    logic              r_act;
    logic              r_write;
    logic              r_illegal;
    logic [2:0]        r_size;
    logic [1:0]        r_lane;
    logic [MEM_AW-1:0] r_word;
    logic [31:0]       r_mem [2**MEM_AW];

    logic              w_accept;
    logic              w_illegal;
    logic              w_hi;
    logic              w_ready;
    logic              w_err;
    logic              w_we;
    logic              w_rd;
    logic [3:0]        w_be;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_unused = bus.HTRANS[0];

    assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & w_ready;
    assign w_hi     = |(bus.HADDR >> (MEM_AW + 2));
    assign w_illegal = (bus.HSIZE > 3'd2)
                     | ((bus.HSIZE == 3'd1) & bus.HADDR[0])
                     | ((bus.HSIZE == 3'd2) & (|bus.HADDR[1:0]))
                     | w_hi;

    // Address-phase capture; only a real accept leaves r_act set.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_act     <= 1'b0;
            r_write   <= 1'b0;
            r_illegal <= 1'b0;
            r_size    <= '0;
            r_lane    <= '0;
            r_word    <= '0;
        end else if (bus.HREADY & w_ready) begin
            r_act     <= w_accept;
            r_write   <= bus.HWRITE;
            r_illegal <= w_accept & w_illegal;
            r_size    <= bus.HSIZE;
            r_lane    <= bus.HADDR[1:0];
            r_word    <= bus.HADDR[MEM_AW+1:2];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_WAIT)
                r_cnt <= r_cnt - 2'd1;
            else if (w_next == S_WAIT)
                r_cnt <= WS;
            else
                r_cnt <= '0;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_ERR2: begin
                if (!w_accept)
                    w_next = S_IDLE;
                else if (w_illegal)
                    w_next = S_ERR1;
                else if (WAIT_STATES > 0)
                    w_next = S_WAIT;
                else
                    w_next = S_IDLE;
            end
            S_WAIT: begin
                if (r_cnt <= 2'd1)
                    w_next = S_IDLE;
            end
            S_ERR1:  w_next = S_ERR2;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = 1'b1;
        w_err   = 1'b0;
        unique case (r_state)
            S_WAIT: w_ready = 1'b0;
            S_ERR1: begin
                w_ready = 1'b0;
                w_err   = 1'b1;
            end
            S_ERR2:  w_err = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        unique case (r_size)
            3'd0:    w_be = 4'b0001 << r_lane;
            3'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Data phases finish only in IDLE, so writes land at that edge.
    assign w_we = ~HRESET & r_act & r_write & ~r_illegal
                & (r_state == S_IDLE);
    assign w_rd = r_act & ~r_write & ~r_illegal & (r_state == S_IDLE);

    always_ff @(posedge HCLK) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b])
                    r_mem[r_word][8*b +: 8] <= bus.HWDATA[8*b +: 8];
            end
        end
    end

    assign w_rdata = w_rd ? r_mem[r_word] : '0;

    assign bus.HREADYOUT = w_ready;
    assign bus.HRESP     = {1'b0, w_err};
    assign bus.HRDATA    = w_rdata;
    assign bus.HRUSER    = {28'd0, ^w_rdata[31:24], ^w_rdata[23:16],
                            ^w_rdata[15:8], ^w_rdata[7:0]};
endmodule

// File: tb/tb_l1_ahb_mem_responder.sv
// Bench for l1_ahb_mem_responder at 0, 2 and 3 wait states: directed
// scenarios plus randomized traffic against a byte-level memory model.
module tb_l1_ahb_mem_responder;
    logic        clk = 1'b0;
    logic        t_rst;
    logic        t_sel;
    logic [31:0] t_addr;
    logic [1:0]  t_trans;
    logic        t_write;
    logic [2:0]  t_size;
    logic [31:0] t_wdata;
    logic [1:0]  cur;

    logic        o_rdy;
    logic [1:0]  o_resp;
    logic [31:0] o_rdata;
    logic [31:0] o_ruser;

    int n_pass = 0;
    int n_total = 0;
    int n_ops;

    logic        op_sel   [64];
    logic [1:0]  op_trans [64];
    logic        op_w     [64];
    logic [31:0] op_a     [64];
    logic [2:0]  op_s     [64];
    logic [31:0] op_d     [64];

    int          rec_low   [64];
    logic [1:0]  rec_lresp [64];
    logic [1:0]  rec_resp  [64];
    logic [31:0] rec_rdata [64];
    logic [31:0] rec_ruser [64];

    always #5 clk = ~clk;

    l1_ahb_mem_responder_if if0 ();
    l1_ahb_mem_responder_if if1 ();
    l1_ahb_mem_responder_if if2 ();

    assign if0.HSEL   = t_sel & (cur == 2'd0);
    assign if0.HADDR  = t_addr;
    assign if0.HTRANS = t_trans;
    assign if0.HWRITE = t_write;
    assign if0.HSIZE  = t_size;
    assign if0.HWDATA = t_wdata;
    assign if0.HREADY = if0.HREADYOUT;

    assign if1.HSEL   = t_sel & (cur == 2'd1);
    assign if1.HADDR  = t_addr;
    assign if1.HTRANS = t_trans;
    assign if1.HWRITE = t_write;
    assign if1.HSIZE  = t_size;
    assign if1.HWDATA = t_wdata;
    assign if1.HREADY = if1.HREADYOUT;

    assign if2.HSEL   = t_sel & (cur == 2'd2);
    assign if2.HADDR  = t_addr;
    assign if2.HTRANS = t_trans;
    assign if2.HWRITE = t_write;
    assign if2.HSIZE  = t_size;
    assign if2.HWDATA = t_wdata;
    assign if2.HREADY = if2.HREADYOUT;

    l1_ahb_mem_responder #(.MEM_AW(12), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESET(t_rst), .bus(if0.slave));
    l1_ahb_mem_responder #(.MEM_AW(12), .WAIT_STATES(2)) u_ws2 (
        .HCLK(clk), .HRESET(t_rst), .bus(if1.slave));
    l1_ahb_mem_responder #(.MEM_AW(12), .WAIT_STATES(3)) u_ws3 (
        .HCLK(clk), .HRESET(t_rst), .bus(if2.slave));

    always_comb begin
        case (cur)
            2'd1: begin
                o_rdy = if1.HREADYOUT; o_resp = if1.HRESP;
                o_rdata = if1.HRDATA; o_ruser = if1.HRUSER;
            end
            2'd2: begin
                o_rdy = if2.HREADYOUT; o_resp = if2.HRESP;
                o_rdata = if2.HRDATA; o_ruser = if2.HRUSER;
            end
            default: begin
                o_rdy = if0.HREADYOUT; o_resp = if0.HRESP;
                o_rdata = if0.HRDATA; o_ruser = if0.HRUSER;
            end
        endcase
    end

    function automatic logic [31:0] par(input logic [31:0] d);
        logic [31:0] p;
        int c;
        p = '0;
        for (int b = 0; b < 4; b++) begin
            c = 0;
            for (int j = 0; j < 8; j++) c += int'(d[8*b+j]);
            p[b] = (c % 2) == 1;
        end
        return p;
    endfunction

    task automatic set_op(input int k, input logic s, input logic [1:0] tr,
                          input logic w, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] d);
        op_sel[k] = s; op_trans[k] = tr; op_w[k] = w;
        op_a[k] = a; op_s[k] = sz; op_d[k] = d;
    endtask

    task automatic drive_addr(input int k);
        if (k < 0) begin
            t_sel = 1'b0; t_trans = 2'b00; t_write = 1'b0;
            t_addr = '0; t_size = '0;
        end else begin
            t_sel = op_sel[k]; t_trans = op_trans[k]; t_write = op_w[k];
            t_addr = op_a[k]; t_size = op_s[k];
        end
    endtask

    task automatic select(input logic [1:0] k);
        cur = k;
        @(negedge clk);
    endtask

    // Pipelined master: records what each data phase looked like.
    task automatic run_ops();
        int ak = -1;
        int dk = 0;
        int i = 0;
        int done = 0;
        int cyc = 0;
        bit dv = 0;
        bit adv;
        drive_addr(-1);
        while (done < n_ops) begin
            @(negedge clk);
            adv = 0;
            cyc++;
            if (cyc > 8 * n_ops + 40) begin
                n_total++;
                $display("FAIL run_ops timeout: done %0d want %0d", done, n_ops);
                break;
            end
            if (!o_rdy) begin
                if (dv) begin
                    if (rec_low[dk] == 0) rec_lresp[dk] = o_resp;
                    rec_low[dk]++;
                end
            end else begin
                if (dv) begin
                    rec_resp[dk] = o_resp;
                    rec_rdata[dk] = o_rdata;
                    rec_ruser[dk] = o_ruser;
                    done++;
                end
                dv = (ak >= 0);
                dk = ak;
                if (dv) begin
                    rec_low[dk] = 0;
                    rec_lresp[dk] = 2'b00;
                end
                adv = 1;
            end
            @(posedge clk);
            #1;
            if (adv) begin
                ak = (i < n_ops) ? i : -1;
                if (i < n_ops) i++;
                drive_addr(ak);
                t_wdata = dv ? op_d[dk] : 32'd0;
            end
        end
        drive_addr(-1);
        @(negedge clk);
    endtask

    task automatic test_reset();
        t_rst = 1'b1;
        drive_addr(-1);
        t_wdata = '0;
        cur = 2'd0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            cur = 2'(k);
            #1;
            n_total++;
            if (o_rdy !== 1'b1) $display("FAIL reset dut%0d ready: got %b want 1", k, o_rdy);
            else n_pass++;
            n_total++;
            if (o_resp !== 2'b00) $display("FAIL reset dut%0d resp: got %b want 00", k, o_resp);
            else n_pass++;
            n_total++;
            if (o_rdata !== 32'd0) $display("FAIL reset dut%0d rdata: got %h want 0", k, o_rdata);
            else n_pass++;
            n_total++;
            if (o_ruser !== 32'd0) $display("FAIL reset dut%0d ruser: got %h want 0", k, o_ruser);
            else n_pass++;
        end
        @(negedge clk);
        t_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp = 32'hDEADBEEF;
        select(2'd0);
        set_op(0, 1'b1, 2'b10, 1'b1, 32'h10, 3'd2, exp);
        set_op(1, 1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'd0);
        n_ops = 2;
        run_ops();
        n_total++;
        if (rec_low[1] !== 0) $display("FAIL b2b low: got %0d want 0", rec_low[1]);
        else n_pass++;
        n_total++;
        if (rec_rdata[1] !== exp) $display("FAIL b2b rdata: got %h want %h", rec_rdata[1], exp);
        else n_pass++;
        n_total++;
        if (rec_ruser[1] !== par(exp)) $display("FAIL b2b ruser: got %h want %h", rec_ruser[1], par(exp));
        else n_pass++;
    endtask

    task automatic test_byte_write();
        select(2'd0);
        set_op(0, 1'b1, 2'b10, 1'b1, 32'h10, 3'd2, 32'h11223344);
        set_op(1, 1'b1, 2'b10, 1'b1, 32'h13, 3'd0, 32'hAA000000);
        set_op(2, 1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'd0);
        n_ops = 3;
        run_ops();
        n_total++;
        if (rec_rdata[2] !== 32'hAA223344) $display("FAIL byte rdata: got %h want aa223344", rec_rdata[2]);
        else n_pass++;
        n_total++;
        if (rec_ruser[2] !== par(32'hAA223344)) $display("FAIL byte ruser: got %h want %h", rec_ruser[2], par(32'hAA223344));
        else n_pass++;
    endtask

    task automatic test_wait_states();
        select(2'd1);
        set_op(0, 1'b1, 2'b10, 1'b1, 32'h20, 3'd2, 32'hCAFEF00D);
        set_op(1, 1'b1, 2'b10, 1'b0, 32'h20, 3'd2, 32'd0);
        n_ops = 2;
        run_ops();
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (rec_low[k] !== 2) $display("FAIL ws2 op%0d low: got %0d want 2", k, rec_low[k]);
            else n_pass++;
            n_total++;
            if (rec_resp[k] !== 2'b00) $display("FAIL ws2 op%0d resp: got %b want 00", k, rec_resp[k]);
            else n_pass++;
        end
        n_total++;
        if (rec_rdata[1] !== 32'hCAFEF00D) $display("FAIL ws2 rdata: got %h want cafef00d", rec_rdata[1]);
        else n_pass++;
    endtask

    task automatic test_error();
        select(2'd0);
        set_op(0, 1'b1, 2'b10, 1'b1, 32'h10, 3'd2, 32'h55AA00FF);
        set_op(1, 1'b1, 2'b10, 1'b0, 32'h02, 3'd2, 32'd0);
        set_op(2, 1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'd0);
        n_ops = 3;
        run_ops();
        n_total++;
        if (rec_low[1] !== 1) $display("FAIL err low: got %0d want 1", rec_low[1]);
        else n_pass++;
        n_total++;
        if (rec_lresp[1] !== 2'b01) $display("FAIL err cycle1 resp: got %b want 01", rec_lresp[1]);
        else n_pass++;
        n_total++;
        if (rec_resp[1] !== 2'b01) $display("FAIL err cycle2 resp: got %b want 01", rec_resp[1]);
        else n_pass++;
        n_total++;
        if (rec_rdata[1] !== 32'd0) $display("FAIL err rdata: got %h want 0", rec_rdata[1]);
        else n_pass++;
        n_total++;
        if (rec_low[2] !== 0 || rec_resp[2] !== 2'b00)
            $display("FAIL err next read: got low %0d resp %b want 0/00", rec_low[2], rec_resp[2]);
        else n_pass++;
        n_total++;
        if (rec_rdata[2] !== 32'h55AA00FF) $display("FAIL err next rdata: got %h want 55aa00ff", rec_rdata[2]);
        else n_pass++;
    endtask

    task automatic test_range_busy();
        select(2'd0);
        set_op(0, 1'b1, 2'b10, 1'b1, 32'h0, 3'd2, 32'h0BADC0DE);
        set_op(1, 1'b1, 2'b10, 1'b1, 32'h0001_0000, 3'd2, 32'hFFFFFFFF);
        set_op(2, 1'b1, 2'b10, 1'b0, 32'h0, 3'd2, 32'd0);
        set_op(3, 1'b1, 2'b01, 1'b0, 32'h0, 3'd2, 32'd0);
        n_ops = 4;
        run_ops();
        n_total++;
        if (rec_low[1] !== 1 || rec_lresp[1] !== 2'b01 || rec_resp[1] !== 2'b01)
            $display("FAIL range err: got low %0d resp %b/%b want 1 01/01",
                     rec_low[1], rec_lresp[1], rec_resp[1]);
        else n_pass++;
        n_total++;
        if (rec_rdata[2] !== 32'h0BADC0DE) $display("FAIL range mem: got %h want 0badc0de", rec_rdata[2]);
        else n_pass++;
        n_total++;
        if (rec_low[3] !== 0 || rec_resp[3] !== 2'b00 || rec_rdata[3] !== 32'd0)
            $display("FAIL busy: got low %0d resp %b rdata %h want 0 00 0",
                     rec_low[3], rec_resp[3], rec_rdata[3]);
        else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        select(2'd2);
        set_op(0, 1'b1, 2'b10, 1'b1, 32'h40, 3'd2, 32'h11111111);
        n_ops = 1;
        run_ops();
        t_sel = 1'b1; t_trans = 2'b10; t_write = 1'b1;
        t_addr = 32'h40; t_size = 3'd2;
        @(negedge clk);
        drive_addr(-1);
        t_wdata = 32'h22222222;
        n_total++;
        if (o_rdy !== 1'b0) $display("FAIL rstwait cycle1 ready: got %b want 0", o_rdy);
        else n_pass++;
        t_rst = 1'b1;
        @(negedge clk);
        t_rst = 1'b0;
        t_wdata = '0;
        n_total++;
        if (o_rdy !== 1'b1 || o_resp !== 2'b00)
            $display("FAIL rstwait after: got ready %b resp %b want 1 00", o_rdy, o_resp);
        else n_pass++;
        set_op(0, 1'b1, 2'b10, 1'b0, 32'h40, 3'd2, 32'd0);
        n_ops = 1;
        run_ops();
        n_total++;
        if (rec_rdata[0] !== 32'h11111111) $display("FAIL rstwait mem: got %h want 11111111", rec_rdata[0]);
        else n_pass++;
        n_total++;
        if (rec_low[0] !== 3) $display("FAIL rstwait read low: got %0d want 3", rec_low[0]);
        else n_pass++;
    endtask

    task automatic test_random(input logic [1:0] idx, input int ws);
        localparam logic [31:0] BASE = 32'h200;
        logic [31:0] m [16];
        logic [31:0] a;
        logic [31:0] exp_rd;
        int r, off, nb, st, lane, exp_low;
        bit xfer, ill;
        select(idx);
        for (int k = 0; k < 16; k++) begin
            m[k] = $urandom;
            set_op(k, 1'b1, 2'b10, 1'b1, BASE + 32'(4 * k), 3'd2, m[k]);
        end
        n_ops = 16;
        run_ops();
        for (int k = 0; k < 16; k++) begin
            n_total++;
            if (rec_low[k] !== ws) $display("FAIL fill ws%0d op%0d low: got %0d want %0d", ws, k, rec_low[k], ws);
            else n_pass++;
        end
        for (int k = 0; k < 48; k++) begin
            r = int'($urandom_range(0, 7));
            a = (r == 0) ? 32'h0001_0000 + $urandom_range(0, 63)
                         : BASE + $urandom_range(0, 63);
            r = int'($urandom_range(0, 9));
            set_op(k, $urandom_range(0, 7) != 0,
                   ($urandom_range(0, 3) != 0) ? 2'(2 + $urandom_range(0, 1))
                                               : 2'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), a,
                   (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2
                                 : 3'($urandom_range(3, 7)),
                   $urandom);
        end
        n_ops = 48;
        run_ops();
        for (int k = 0; k < 48; k++) begin
            xfer = op_sel[k] && op_trans[k][1];
            nb = 1 << op_s[k];
            ill = xfer && (op_s[k] > 2 || op_a[k] % nb != 0
                           || op_a[k] >= 32'h4000);
            exp_low = !xfer ? 0 : ill ? 1 : ws;
            exp_rd = '0;
            if (xfer && !ill) begin
                off = int'(op_a[k] - BASE);
                if (!op_w[k]) begin
                    exp_rd = m[off / 4];
                end else begin
                    st = off - off % nb;
                    for (int j = 0; j < nb; j++) begin
                        lane = (st + j) % 4;
                        m[off / 4][8*lane +: 8] = op_d[k][8*lane +: 8];
                    end
                end
            end
            n_total++;
            if (rec_low[k] !== exp_low)
                $display("FAIL rand ws%0d op%0d low: got %0d want %0d", ws, k, rec_low[k], exp_low);
            else n_pass++;
            n_total++;
            if (rec_resp[k] !== {1'b0, ill})
                $display("FAIL rand ws%0d op%0d resp: got %b want %b", ws, k, rec_resp[k], {1'b0, ill});
            else n_pass++;
            n_total++;
            if (rec_rdata[k] !== exp_rd)
                $display("FAIL rand ws%0d op%0d rdata: got %h want %h", ws, k, rec_rdata[k], exp_rd);
            else n_pass++;
            n_total++;
            if (rec_ruser[k] !== par(exp_rd))
                $display("FAIL rand ws%0d op%0d ruser: got %h want %h", ws, k, rec_ruser[k], par(exp_rd));
            else n_pass++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_write();
        test_wait_states();
        test_error();
        test_range_busy();
        test_reset_in_wait();
        test_random(2'd0, 0);
        test_random(2'd1, 2);
        test_random(2'd2, 3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
